// File: rtl/uart_bridge.sv
// Board-side UART endpoint: 8N1 receiver and transmitter, each buffered by a
// byte FIFO that the core reads/writes through a show-ahead FIFO port.
module uart_bridge #(
   parameter int CLK_PER_BIT = 434,
   parameter int DEPTH_LOG2  = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rxd,
   output logic       txd,
   output logic       uart_empty,
   output logic [7:0] uart_in,
   input  logic       uart_rdreq,
   input  logic [7:0] uart_out,
   input  logic       uart_wrreq,
   output logic       rx_overflow,
   output logic       tx_overflow,
   output logic       frame_err
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int CW    = $clog2(CLK_PER_BIT);
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLK_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLK_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] STOP_LAST = CW'(CLK_PER_BIT - 2);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);

   typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rx_state_t;
   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

   logic rx_meta, rx_sync;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
      end else begin
         rx_meta <= rxd;
         rx_sync <= rx_meta;
      end
   end

   rx_state_t       rx_state, rx_next;
   logic [CW-1:0]   rx_cnt;
   logic [2:0]      rx_bit;
   logic [7:0]      rx_shift;
   logic            rx_push, rx_bad_stop;
   logic            rx_half_tick, rx_bit_tick;

   assign rx_half_tick = (rx_cnt == HALF_LAST);
   assign rx_bit_tick  = (rx_cnt == BIT_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rx_state <= RX_IDLE;
      else        rx_state <= rx_next;
   end

   always_comb begin
      rx_next = rx_state;
      case (rx_state)
         RX_IDLE:      if (!rx_sync) rx_next = RX_START;
         RX_START:     if (rx_half_tick) rx_next = rx_sync ? RX_IDLE : RX_DATA;
         RX_DATA:      if (rx_bit_tick && rx_bit == 3'd7) rx_next = RX_STOP;
         RX_STOP:      if (rx_bit_tick) rx_next = rx_sync ? RX_IDLE : RX_WAIT_HIGH;
         RX_WAIT_HIGH: if (rx_sync) rx_next = RX_IDLE;
         default:      rx_next = RX_IDLE;
      endcase
   end

   always_comb begin
      rx_push     = 1'b0;
      rx_bad_stop = 1'b0;
      if (rx_state == RX_STOP && rx_bit_tick) begin
         rx_push     = rx_sync;
         rx_bad_stop = !rx_sync;
      end
   end

   // The counter is preloaded to 1 in IDLE so the start-bit check lands
   // CLK_PER_BIT/2 cycles after the synchronized falling edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_cnt   <= '0;
         rx_bit   <= '0;
         rx_shift <= '0;
      end else begin
         case (rx_state)
            RX_START: begin
               rx_bit <= '0;
               rx_cnt <= rx_half_tick ? '0 : rx_cnt + 1'b1;
            end
            RX_DATA: begin
               if (rx_bit_tick) begin
                  rx_cnt   <= '0;
                  rx_shift <= {rx_sync, rx_shift[7:1]};
                  rx_bit   <= rx_bit + 1'b1;
               end else begin
                  rx_cnt <= rx_cnt + 1'b1;
               end
            end
            RX_STOP: rx_cnt <= rx_bit_tick ? '0 : rx_cnt + 1'b1;
            default: rx_cnt <= CNT_ONE;
         endcase
      end
   end

   logic [7:0]          rx_mem [DEPTH];
   logic [DEPTH_LOG2:0] rx_wr, rx_rd;
   logic                rx_full, rx_empty, rx_pop, rx_accept;

   assign rx_empty  = (rx_wr == rx_rd);
   assign rx_full   = (rx_wr[DEPTH_LOG2] != rx_rd[DEPTH_LOG2]) &&
                      (rx_wr[DEPTH_LOG2-1:0] == rx_rd[DEPTH_LOG2-1:0]);
   assign rx_pop    = uart_rdreq && !rx_empty;
   assign rx_accept = rx_push && (!rx_full || rx_pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_wr <= '0;
         rx_rd <= '0;
      end else begin
         if (rx_accept) rx_wr <= rx_wr + 1'b1;
         if (rx_pop)    rx_rd <= rx_rd + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rx_accept) rx_mem[rx_wr[DEPTH_LOG2-1:0]] <= rx_shift;
   end

   assign uart_empty = rx_empty;
   assign uart_in    = rx_empty ? 8'h00 : rx_mem[rx_rd[DEPTH_LOG2-1:0]];

   logic [7:0]          tx_mem [DEPTH];
   logic [DEPTH_LOG2:0] tx_wr, tx_rd;
   logic                tx_full, tx_empty, tx_pop, tx_accept;
   logic [7:0]          tx_head;

   assign tx_empty  = (tx_wr == tx_rd);
   assign tx_full   = (tx_wr[DEPTH_LOG2] != tx_rd[DEPTH_LOG2]) &&
                      (tx_wr[DEPTH_LOG2-1:0] == tx_rd[DEPTH_LOG2-1:0]);
   assign tx_accept = uart_wrreq && (!tx_full || tx_pop);
   assign tx_head   = tx_mem[tx_rd[DEPTH_LOG2-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_wr <= '0;
         tx_rd <= '0;
      end else begin
         if (tx_accept) tx_wr <= tx_wr + 1'b1;
         if (tx_pop)    tx_rd <= tx_rd + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (tx_accept) tx_mem[tx_wr[DEPTH_LOG2-1:0]] <= uart_out;
   end

   tx_state_t     tx_state, tx_next;
   logic [CW-1:0] tx_cnt;
   logic [2:0]    tx_bit;
   logic [7:0]    tx_shift;
   logic          tx_bit_tick, tx_stop_tick;

   assign tx_bit_tick  = (tx_cnt == BIT_LAST);
   assign tx_stop_tick = (tx_cnt == STOP_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) tx_state <= TX_IDLE;
      else        tx_state <= tx_next;
   end

   // STOP ends one cycle early because the IDLE cycle that pops the next byte
   // still drives the stop level, keeping every frame exactly 10 bit periods.
   always_comb begin
      tx_next = tx_state;
      case (tx_state)
         TX_IDLE:  if (!tx_empty) tx_next = TX_START;
         TX_START: if (tx_bit_tick) tx_next = TX_DATA;
         TX_DATA:  if (tx_bit_tick && tx_bit == 3'd7) tx_next = TX_STOP;
         TX_STOP:  if (tx_stop_tick) tx_next = TX_IDLE;
         default:  tx_next = TX_IDLE;
      endcase
   end

   always_comb begin
      tx_pop = (tx_state == TX_IDLE) && !tx_empty;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         txd      <= 1'b1;
         tx_cnt   <= '0;
         tx_bit   <= '0;
         tx_shift <= '0;
      end else begin
         case (tx_state)
            TX_IDLE: begin
               tx_cnt <= '0;
               tx_bit <= '0;
               if (tx_pop) begin
                  tx_shift <= tx_head;
                  txd      <= 1'b0;
               end
            end
            TX_START: begin
               if (tx_bit_tick) begin
                  tx_cnt   <= '0;
                  txd      <= tx_shift[0];
                  tx_shift <= {1'b0, tx_shift[7:1]};
               end else begin
                  tx_cnt <= tx_cnt + 1'b1;
               end
            end
            TX_DATA: begin
               if (tx_bit_tick) begin
                  tx_cnt <= '0;
                  if (tx_bit == 3'd7) begin
                     txd <= 1'b1;
                  end else begin
                     txd      <= tx_shift[0];
                     tx_shift <= {1'b0, tx_shift[7:1]};
                     tx_bit   <= tx_bit + 1'b1;
                  end
               end else begin
                  tx_cnt <= tx_cnt + 1'b1;
               end
            end
            default: tx_cnt <= tx_stop_tick ? '0 : tx_cnt + 1'b1;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_overflow <= 1'b0;
         tx_overflow <= 1'b0;
         frame_err   <= 1'b0;
      end else begin
         if (rx_push && !rx_accept)   rx_overflow <= 1'b1;
         if (uart_wrreq && !tx_accept) tx_overflow <= 1'b1;
         if (rx_bad_stop)             frame_err   <= 1'b1;
      end
   end

endmodule

// File: tb/tb_uart_bridge.sv
// Self-checking bench for uart_bridge with CLK_PER_BIT=16 and 4-deep FIFOs;
// expected bytes go into scoreboard queues and are popped as the DUT delivers.
module tb_uart_bridge;

   localparam int CPB = 16;
   localparam int DL2 = 2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rxd = 1'b1;
   logic       uart_rdreq = 1'b0;
   logic       uart_wrreq = 1'b0;
   logic [7:0] uart_out = 8'h00;
   logic       txd, uart_empty, rx_overflow, tx_overflow, frame_err;
   logic [7:0] uart_in;

   int         checks = 0;
   int         passed = 0;
   int         rx_latency = 154;
   logic [7:0] rx_exp[$];
   logic [7:0] tx_exp[$];

   uart_bridge #(.CLK_PER_BIT(CPB), .DEPTH_LOG2(DL2)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .rxd(rxd),
      .txd(txd),
      .uart_empty(uart_empty),
      .uart_in(uart_in),
      .uart_rdreq(uart_rdreq),
      .uart_out(uart_out),
      .uart_wrreq(uart_wrreq),
      .rx_overflow(rx_overflow),
      .tx_overflow(tx_overflow),
      .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   // Stimulus drivers; all are entered and left on a falling clock edge.
   task automatic send_frame(input logic [7:0] b, input logic stop);
      rxd = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         repeat (CPB) @(negedge clk);
      end
      rxd = stop;
      repeat (CPB) @(negedge clk);
   endtask

   task automatic pop_rx;
      uart_rdreq = 1'b1;
      @(negedge clk);
      uart_rdreq = 1'b0;
   endtask

   task automatic do_reset;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   // Line decoder: waits for a start bit, then samples every cycle of 10 bits.
   task automatic capture_tx(output logic [9:0] bits, output logic stable, output int waited);
      waited = 0;
      stable = 1'b1;
      bits   = '0;
      while (txd === 1'b1 && waited < 400) begin
         @(negedge clk);
         waited++;
      end
      for (int k = 0; k < 10; k++) begin
         bits[k] = txd;
         for (int j = 0; j < CPB; j++) begin
            if (txd !== bits[k]) stable = 1'b0;
            @(negedge clk);
         end
      end
   endtask

   task automatic test_reset;
      repeat (3) @(negedge clk);
      checks++; if (txd !== 1'b1) $display("[TB] FAIL reset_txd: got %b expected 1", txd); else passed++;
      checks++; if (uart_empty !== 1'b1) $display("[TB] FAIL reset_empty: got %b expected 1", uart_empty); else passed++;
      checks++; if (uart_in !== 8'h00) $display("[TB] FAIL reset_uart_in: got %h expected 00", uart_in); else passed++;
      checks++;
      if ({rx_overflow, tx_overflow, frame_err} !== 3'b000)
         $display("[TB] FAIL reset_flags: got %b expected 000", {rx_overflow, tx_overflow, frame_err});
      else passed++;
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({txd, uart_empty} !== 2'b11) $display("[TB] FAIL post_reset_idle: got %b expected 11", {txd, uart_empty});
      else passed++;
   endtask

   task automatic test_rx_single;
      int n;
      logic [7:0] exp;
      rx_exp.push_back(8'hA5);
      n = 0;
      fork
         send_frame(8'hA5, 1'b1);
         begin
            while (uart_empty === 1'b1 && n < 400) begin
               @(negedge clk);
               n++;
            end
         end
      join
      checks++;
      if (n < 153 || n > 155) $display("[TB] FAIL rx_latency: got %0d cycles expected 153..155", n);
      else passed++;
      rx_latency = n;
      exp = rx_exp.pop_front();
      checks++;
      if ({uart_empty, uart_in} !== {1'b0, exp})
         $display("[TB] FAIL rx_single_byte: got empty=%b data=%h expected empty=0 data=%h", uart_empty, uart_in, exp);
      else passed++;
      pop_rx();
      checks++; if (uart_empty !== 1'b1) $display("[TB] FAIL rx_single_pop: got empty=%b expected 1", uart_empty); else passed++;
   endtask

   task automatic test_tx_back_to_back;
      logic [9:0] bits, frame;
      logic       stable;
      int         waited;
      logic [7:0] exp;
      tx_exp.push_back(8'h3C);
      tx_exp.push_back(8'hFF);
      uart_out   = 8'h3C;
      uart_wrreq = 1'b1;
      @(negedge clk);
      checks++; if (txd !== 1'b1) $display("[TB] FAIL tx_latency_early: got %b expected 1", txd); else passed++;
      uart_out = 8'hFF;
      @(negedge clk);
      uart_wrreq = 1'b0;
      checks++; if (txd !== 1'b0) $display("[TB] FAIL tx_latency: got %b expected 0", txd); else passed++;
      for (int f = 0; f < 2; f++) begin
         capture_tx(bits, stable, waited);
         exp   = tx_exp.pop_front();
         frame = {1'b1, exp, 1'b0};
         checks++; if (waited !== 0) $display("[TB] FAIL tx_gap%0d: got %0d idle cycles expected 0", f, waited); else passed++;
         checks++; if (bits !== frame) $display("[TB] FAIL tx_frame%0d: got %b expected %b", f, bits, frame); else passed++;
         checks++; if (stable !== 1'b1) $display("[TB] FAIL tx_bit_width%0d: got unstable bits expected 16-cycle bits", f); else passed++;
      end
      stable = 1'b1;
      repeat (20) begin
         if (txd !== 1'b1) stable = 1'b0;
         @(negedge clk);
      end
      checks++; if (stable !== 1'b1) $display("[TB] FAIL tx_idle_after: got activity expected idle high"); else passed++;
   endtask

   task automatic test_overflow;
      logic [9:0] bits, frame;
      logic       stable;
      int         waited;
      logic [7:0] exp;
      for (int i = 0; i < 5; i++) tx_exp.push_back(8'h10 + 8'(i));
      fork
         begin
            for (int i = 0; i < 6; i++) begin
               uart_out   = 8'h10 + 8'(i);
               uart_wrreq = 1'b1;
               @(negedge clk);
               if (i == 4) begin
                  checks++; if (tx_overflow !== 1'b0) $display("[TB] FAIL tx_overflow_early: got %b expected 0", tx_overflow); else passed++;
               end
            end
            uart_wrreq = 1'b0;
            checks++; if (tx_overflow !== 1'b1) $display("[TB] FAIL tx_overflow_set: got %b expected 1", tx_overflow); else passed++;
         end
         begin
            for (int f = 0; f < 5; f++) begin
               capture_tx(bits, stable, waited);
               exp   = tx_exp.pop_front();
               frame = {1'b1, exp, 1'b0};
               checks++;
               if (bits !== frame || stable !== 1'b1 || waited >= 400)
                  $display("[TB] FAIL tx_ovf_frame%0d: got %b stable=%b expected %b", f, bits, stable, frame);
               else passed++;
            end
         end
      join
      stable = 1'b1;
      repeat (40) begin
         if (txd !== 1'b1) stable = 1'b0;
         @(negedge clk);
      end
      checks++; if (stable !== 1'b1) $display("[TB] FAIL tx_dropped_sent: got a sixth frame expected idle"); else passed++;

      for (int i = 0; i < 4; i++) rx_exp.push_back(8'h41 + 8'(i));
      for (int i = 0; i < 4; i++) send_frame(8'h41 + 8'(i), 1'b1);
      checks++; if (rx_overflow !== 1'b0) $display("[TB] FAIL rx_overflow_early: got %b expected 0", rx_overflow); else passed++;
      send_frame(8'h45, 1'b1);
      checks++; if (rx_overflow !== 1'b1) $display("[TB] FAIL rx_overflow_set: got %b expected 1", rx_overflow); else passed++;
      for (int i = 0; i < 4; i++) begin
         exp = rx_exp.pop_front();
         checks++;
         if ({uart_empty, uart_in} !== {1'b0, exp})
            $display("[TB] FAIL rx_ovf_byte%0d: got empty=%b data=%h expected empty=0 data=%h", i, uart_empty, uart_in, exp);
         else passed++;
         pop_rx();
      end
      checks++; if (uart_empty !== 1'b1) $display("[TB] FAIL rx_ovf_drained: got empty=%b expected 1", uart_empty); else passed++;
   endtask

   task automatic test_framing;
      logic [7:0] exp;
      send_frame(8'h55, 1'b0);
      checks++; if (uart_empty !== 1'b1) $display("[TB] FAIL frame_err_push: got empty=%b expected 1", uart_empty); else passed++;
      checks++; if (frame_err !== 1'b1) $display("[TB] FAIL frame_err_set: got %b expected 1", frame_err); else passed++;
      repeat (40 * CPB) @(negedge clk);
      rxd = 1'b1;
      repeat (2 * CPB) @(negedge clk);
      checks++;
      if ({uart_empty, frame_err} !== 2'b11)
         $display("[TB] FAIL break_release: got empty=%b frame_err=%b expected 1 1", uart_empty, frame_err);
      else passed++;
      rx_exp.push_back(8'h96);
      send_frame(8'h96, 1'b1);
      exp = rx_exp.pop_front();
      checks++;
      if ({uart_empty, uart_in} !== {1'b0, exp})
         $display("[TB] FAIL after_break_byte: got empty=%b data=%h expected empty=0 data=%h", uart_empty, uart_in, exp);
      else passed++;
      pop_rx();
      rxd = 1'b0;
      repeat (3) @(negedge clk);
      rxd = 1'b1;
      repeat (300) @(negedge clk);
      checks++; if (uart_empty !== 1'b1) $display("[TB] FAIL glitch_push: got empty=%b expected 1", uart_empty); else passed++;
   endtask

   task automatic test_simul_push_pop;
      logic [7:0] exp;
      do_reset();
      rx_exp.push_back(8'h11);
      send_frame(8'h11, 1'b1);
      rx_exp.push_back(8'h22);
      fork
         send_frame(8'h22, 1'b1);
         begin
            repeat (rx_latency - 1) @(negedge clk);
            exp = rx_exp.pop_front();
            checks++;
            if ({uart_empty, uart_in} !== {1'b0, exp})
               $display("[TB] FAIL simul1_head: got empty=%b data=%h expected empty=0 data=%h", uart_empty, uart_in, exp);
            else passed++;
            uart_rdreq = 1'b1;
            @(negedge clk);
            uart_rdreq = 1'b0;
            checks++;
            if ({uart_empty, uart_in} !== {1'b0, rx_exp[0]})
               $display("[TB] FAIL simul1_new: got empty=%b data=%h expected empty=0 data=%h", uart_empty, uart_in, rx_exp[0]);
            else passed++;
         end
      join
      void'(rx_exp.pop_front());
      pop_rx();
      checks++; if (uart_empty !== 1'b1) $display("[TB] FAIL simul1_count: got empty=%b expected 1", uart_empty); else passed++;

      for (int i = 0; i < 4; i++) rx_exp.push_back(8'h31 + 8'(i));
      for (int i = 0; i < 4; i++) send_frame(8'h31 + 8'(i), 1'b1);
      rx_exp.push_back(8'h35);
      fork
         send_frame(8'h35, 1'b1);
         begin
            repeat (rx_latency - 1) @(negedge clk);
            exp = rx_exp.pop_front();
            checks++;
            if (uart_in !== exp) $display("[TB] FAIL simul_full_head: got %h expected %h", uart_in, exp); else passed++;
            uart_rdreq = 1'b1;
            @(negedge clk);
            uart_rdreq = 1'b0;
         end
      join
      checks++; if (rx_overflow !== 1'b0) $display("[TB] FAIL simul_full_overflow: got %b expected 0", rx_overflow); else passed++;
      for (int i = 0; i < 4; i++) begin
         exp = rx_exp.pop_front();
         checks++;
         if ({uart_empty, uart_in} !== {1'b0, exp})
            $display("[TB] FAIL simul_full_byte%0d: got empty=%b data=%h expected empty=0 data=%h", i, uart_empty, uart_in, exp);
         else passed++;
         pop_rx();
      end
      checks++; if (uart_empty !== 1'b1) $display("[TB] FAIL simul_full_drained: got empty=%b expected 1", uart_empty); else passed++;
   endtask

   task automatic test_reset_midframe;
      logic [9:0] bits, frame;
      logic       stable;
      int         waited;
      logic [7:0] exp;
      for (int i = 0; i < 6; i++) begin
         uart_out   = 8'h00;
         uart_wrreq = 1'b1;
         @(negedge clk);
      end
      uart_wrreq = 1'b0;
      send_frame(8'h5A, 1'b1);
      send_frame(8'h00, 1'b0);
      rxd = 1'b1;
      repeat (20) @(negedge clk);
      rxd = 1'b0;
      repeat (70) @(negedge clk);
      waited = 0;
      while (txd !== 1'b0 && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      checks++;
      if ({txd, uart_empty, tx_overflow, frame_err} !== 4'b0011)
         $display("[TB] FAIL pre_reset_state: got txd=%b empty=%b tx_ovf=%b ferr=%b expected 0 0 1 1",
                  txd, uart_empty, tx_overflow, frame_err);
      else passed++;
      rst_n = 1'b0;
      #1;
      checks++; if (txd !== 1'b1) $display("[TB] FAIL async_reset_txd: got %b expected 1", txd); else passed++;
      checks++;
      if ({uart_empty, uart_in} !== 9'h100)
         $display("[TB] FAIL async_reset_rx: got empty=%b data=%h expected empty=1 data=00", uart_empty, uart_in);
      else passed++;
      checks++;
      if ({rx_overflow, tx_overflow, frame_err} !== 3'b000)
         $display("[TB] FAIL async_reset_flags: got %b expected 000", {rx_overflow, tx_overflow, frame_err});
      else passed++;
      @(negedge clk);
      rxd = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      stable = 1'b1;
      repeat (30) begin
         if (txd !== 1'b1) stable = 1'b0;
         @(negedge clk);
      end
      checks++; if (stable !== 1'b1) $display("[TB] FAIL tx_fifo_discard: got activity expected idle high"); else passed++;

      tx_exp.push_back(8'hC3);
      fork
         begin
            uart_out   = 8'hC3;
            uart_wrreq = 1'b1;
            @(negedge clk);
            uart_wrreq = 1'b0;
         end
         begin
            capture_tx(bits, stable, waited);
            exp   = tx_exp.pop_front();
            frame = {1'b1, exp, 1'b0};
            checks++;
            if (bits !== frame || stable !== 1'b1 || waited >= 400)
               $display("[TB] FAIL tx_after_reset: got %b stable=%b expected %b", bits, stable, frame);
            else passed++;
         end
      join
      rx_exp.push_back(8'h3A);
      send_frame(8'h3A, 1'b1);
      exp = rx_exp.pop_front();
      checks++;
      if ({uart_empty, uart_in} !== {1'b0, exp})
         $display("[TB] FAIL rx_after_reset: got empty=%b data=%h expected empty=0 data=%h", uart_empty, uart_in, exp);
      else passed++;
      pop_rx();
      checks++; if (uart_empty !== 1'b1) $display("[TB] FAIL rx_after_reset_pop: got empty=%b expected 1", uart_empty); else passed++;
   endtask

   initial begin
      $display("[TB] uart_bridge bench start");
      test_reset();
      test_rx_single();
      test_tx_back_to_back();
      test_overflow();
      test_framing();
      test_simul_push_pop();
      test_reset_midframe();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/uart_bridge.md
# uart_bridge

Serial-side endpoint for the core's byte-FIFO UART port. It receives 8N1 frames on `rxd` into an RX FIFO, which the core drains through `uart_empty`/`uart_in`/`uart_rdreq`. It also accepts bytes from the core through `uart_out`/`uart_wrreq` into a TX FIFO and serializes them onto `txd`. It sits at the top level between the board UART pins and the core's memory-mapped UART I/O.

## Interface

- `CLK_PER_BIT`, default 434: clocks per bit period (50 MHz / 115200). Must be ≥ 4.
- `DEPTH_LOG2`, default 4: each FIFO holds 2^DEPTH_LOG2 bytes.

- `clk`  in  1  sole clock; everything is rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `rxd`  in  1  serial input; asynchronous; idles high.
- `txd`  out  1  serial output; idles high.
- `uart_empty`  out  1  RX FIFO empty.
- `uart_in`  out  8  RX FIFO head byte (show-ahead).
- `uart_rdreq`  in  1  pops the RX head on the edge where it is high.
- `uart_out`  in  8  byte to transmit.
- `uart_wrreq`  in  1  pushes `uart_out` into the TX FIFO on the edge where it is high.
- `rx_overflow`  out  1  sticky; a received byte was dropped because the RX FIFO was full.
- `tx_overflow`  out  1  sticky; a write was dropped because the TX FIFO was full.
- `frame_err`  out  1  sticky; a stop bit was sampled low.

## Operation

- **Reset values:**
  - `txd`=1, `uart_empty`=1, `uart_in`=0, all sticky flags 0.
  - Both FIFOs empty; both FSMs idle.
  - Reset asserted mid-frame aborts the frame immediately. FIFO contents are discarded.
- **Sticky flags** clear only on reset.
- **RX path:**
  - `rxd` passes through a 2-FF synchronizer.
  - RX FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE → START when the synchronized `rxd` is 0.
  - START waits CLK_PER_BIT/2 cycles (integer division), then samples:
    - 1 → IDLE (glitch, nothing recorded).
    - 0 → DATA.
  - DATA takes 8 samples, spaced CLK_PER_BIT cycles apart, LSB first.
  - STOP samples once, CLK_PER_BIT cycles after the last data bit:
    - 1 → push the byte, go to IDLE.
    - 0 → discard the byte, set `frame_err`, go to WAIT_HIGH.
  - WAIT_HIGH → IDLE once `rxd`=1. A held-low break line therefore raises exactly one error and does not retrigger.
  - Push into a full RX FIFO: byte dropped, `rx_overflow` set.
  - Exception: if the push coincides with `uart_rdreq` on a full FIFO, the pop frees a slot and the push is accepted.
- **Core read port:**
  - `uart_in` always shows the head byte while `uart_empty`=0.
  - `uart_rdreq` while empty is ignored and the FIFO state is unchanged.
  - Simultaneous push and pop at count 1: count stays 1, and `uart_in` becomes the new byte.
- **TX path:**
  - `uart_wrreq` into a full TX FIFO: write dropped, `tx_overflow` set. Same-edge pop by the TX FSM frees a slot first.
  - TX FSM states: IDLE, START, DATA, STOP.
  - In IDLE with the TX FIFO non-empty: pop the byte, drive `txd`=0, enter START.
  - Each bit lasts exactly CLK_PER_BIT cycles.
  - Bit order: start(0), d0…d7, stop(1).
  - After STOP completes, the FSM returns to IDLE. If the FIFO is non-empty, the next start bit begins on the very next edge, so frames run back-to-back with no extra idle time.
- **Pointers:** FIFO pointers are DEPTH_LOG2+1 bits and wrap naturally. Full/empty are taken from the MSB comparison.

## Timing

- **TX latency:** a write sampled at edge E into an empty TX FIFO with the FSM idle gives `txd`=0 after edge E+1.
- **TX frame length:** 10·CLK_PER_BIT cycles, measured from the `txd` fall to the earliest start of the next frame.
- **RX latency:**
  - The byte is pushed on the edge that samples the stop bit.
  - `uart_empty` falls and `uart_in` is valid after that same edge.
  - That edge is 2 + CLK_PER_BIT/2 + 9·CLK_PER_BIT cycles after the `rxd` falling edge, ±1 cycle for synchronizer phase.
- **Read port:** a pop at edge E updates `uart_in`/`uart_empty` after E, so the core may pop once per cycle.
- **Sticky flags** rise after the edge that detects the condition.
- Outputs change only on `clk` edges or asynchronously on reset.

## Test plan

Bench parameters: CLK_PER_BIT=16, DEPTH_LOG2=2.

1. **Single RX byte.** Drive the frame 0xA5 on `rxd`. Required: `uart_empty` falls with `uart_in`=0xA5. Then `uart_rdreq` for 1 cycle: `uart_empty`=1.
2. **TX back-to-back.** Write 0x3C and 0xFF on consecutive cycles. Required:
   - `txd`=0 after E+1.
   - Line shows 0,0,0,1,1,1,1,0,0,1 at 16 cycles per bit, then the second frame starts with no idle.
   - Total 320 cycles.
3. **Overflows.**
   - Write 6 bytes on consecutive cycles while the TX FSM is busy. Required: 5 are accepted (4 buffered plus 1 popped), the 6th sets `tx_overflow`.
   - Receive 5 frames without reading. Required: bytes 1–4 are readable in order, `rx_overflow`=1.
4. **Framing and glitch.**
   - Frame 0x55 with stop=0. Required: no push, `frame_err`=1.
   - Then hold `rxd` low 40 bit-times and release. Required: still a single error, and the next valid frame is received correctly.
   - A 3-cycle low glitch on an idle line. Required: nothing is pushed.
5. **Simultaneous RX push and pop.** Hold 1 byte in the RX FIFO and time `uart_rdreq` to the stop-sample edge of a new frame. Required: count stays 1 and `uart_in` equals the new byte. Repeat with the FIFO full: no overflow.
6. **Reset mid-frame.** Pulse `rst_n` low mid-frame during a TX and an RX frame. Required: `txd`=1 immediately (asynchronous), `uart_empty`=1, flags 0, and the next frame is transmitted and received correctly.
